// File: rtl/fp_divider_seq_if.sv
// Run/stall handshake bundle for the sequential FP divider.
//   ce    : clock enable from the core; every divider register update waits on it
//   run   : held high by the core for the whole division
//   x, y  : dividend and divisor, IEEE-754 single, stable while run is high
//   stall : high while the quotient is not yet valid
//   z     : quotient, combinational from x, y and the divider state
interface fp_divider_seq_if;
    logic        ce;
    logic        run;
    logic [31:0] x;
    logic [31:0] y;
    logic        stall;
    logic [31:0] z;

    modport master (
        output ce,
        output run,
        output x,
        output y,
        input  stall,
        input  z
    );

    modport slave (
        input  ce,
        input  run,
        input  x,
        input  y,
        output stall,
        output z
    );
endinterface

// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 single-precision divider, z = x / y.
// One restoring-division step per ce-qualified clock. Mantissas are truncated.
// A zero exponent field is treated as zero. NaN and denormals are not supported.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-low reset of the step counter and datapath
//   bus  : run/stall handshake (ce, run, x, y in; stall, z out)
module fp_divider_seq (
    input  logic            clk,
    input  logic            rst,
    fp_divider_seq_if.slave bus
);
    localparam int unsigned SW = 5;   // step counter width
    localparam int unsigned RW = 25;  // partial remainder width
    localparam int unsigned QW = 25;  // quotient width
    localparam int unsigned MW = 24;  // mantissa width, hidden bit included
    localparam int unsigned EW = 10;  // exponent arithmetic width

    localparam logic [SW-1:0] LAST_STEP = SW'(25);
    localparam logic [SW-1:0] DONE      = SW'(26);

    logic [SW-1:0] r_s;
    logic [SW-1:0] w_s_nxt;
    logic [RW-1:0] r_r;
    logic [RW-1:0] w_r_nxt;
    logic [QW-1:0] r_q;
    logic [QW-1:0] w_q_nxt;

    logic [MW-1:0] w_mx;
    logic [MW-1:0] w_my;
    logic          w_sign;
    logic [7:0]    w_xe;
    logic [7:0]    w_ye;
    logic [RW:0]   w_diff;
    logic [22:0]   w_mant;
    logic [EW-1:0] w_e1;
    logic          w_uflow;
    logic          w_oflow;

    // Operand fields
    assign w_mx   = {1'b1, bus.x[22:0]};
    assign w_my   = {1'b1, bus.y[22:0]};
    assign w_sign = bus.x[31] ^ bus.y[31];
    assign w_xe   = bus.x[30:23];
    assign w_ye   = bus.y[30:23];

    // Trial subtraction; bit 25 set means the divisor did not fit
    assign w_diff = {1'b0, r_r} - {2'b00, w_my};

    // Next-state for counter, remainder and quotient
    always_comb begin
        w_s_nxt = r_s;
        w_r_nxt = r_r;
        w_q_nxt = r_q;
        if (bus.ce) begin
            w_s_nxt = bus.run ? r_s + SW'(1) : '0;
            if (r_s == '0) begin
                w_r_nxt = RW'(w_mx);
                w_q_nxt = '0;
            end else if (r_s <= LAST_STEP) begin
                if (!w_diff[RW]) begin
                    // Remainder stays below 2*my, so dropping the top bit is lossless
                    w_r_nxt = w_diff[RW-1:0] << 1;
                    w_q_nxt = {r_q[QW-2:0], 1'b1};
                end else begin
                    w_r_nxt = r_r << 1;
                    w_q_nxt = {r_q[QW-2:0], 1'b0};
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s <= '0;
            r_r <= '0;
            r_q <= '0;
        end else begin
            r_s <= w_s_nxt;
            r_r <= w_r_nxt;
            r_q <= w_q_nxt;
        end
    end

    // Normalise: Q[24] set means the quotient is already in [1,2)
    assign w_mant = r_q[QW-1] ? r_q[23:1] : r_q[22:0];

    // Biased exponent in 10-bit two's complement so under/overflow are visible
    assign w_e1 = {2'b00, w_xe} - {2'b00, w_ye} + EW'(126) + EW'(r_q[QW-1]);

    assign w_uflow = w_e1[EW-1] | (w_e1 == '0);
    assign w_oflow = !w_e1[EW-1] & (w_e1[8] | (&w_e1[7:0]));

    // Result selection in priority order
    always_comb begin
        bus.z = {w_sign, w_e1[7:0], w_mant};
        if (w_xe == '0) begin
            bus.z = '0;
        end else if (w_ye == '0) begin
            bus.z = {w_sign, 8'hFF, 23'h0};
        end else if (w_uflow) begin
            bus.z = '0;
        end else if (w_oflow) begin
            bus.z = {w_sign, 8'hFF, w_mant};
        end
    end

    assign bus.stall = bus.run & (r_s != DONE);
endmodule

// File: tb/tb_fp_divider_seq.sv
// Self-checking bench for fp_divider_seq: directed vector table, reset/abort
// sequences and randomized divisions against an arithmetic reference model.
module tb_fp_divider_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fp_divider_seq_if bus ();

    fp_divider_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference: exact integer quotient of the mantissas scaled by 2^24, truncated
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint unsigned mx;
        longint unsigned my;
        longint unsigned q;
        int              e;
        logic [22:0]     m;
        logic            s;
        s  = a[31] ^ b[31];
        if (a[30:23] == 8'd0) return 32'h0;
        if (b[30:23] == 8'd0) return {s, 8'hFF, 23'h0};
        mx = longint'({1'b1, a[22:0]});
        my = longint'({1'b1, b[22:0]});
        q  = (mx << 24) / my;
        if (q >= 64'd16777216) begin
            m = 23'(q >> 1);
            e = int'(a[30:23]) - int'(b[30:23]) + 127;
        end else begin
            m = 23'(q);
            e = int'(a[30:23]) - int'(b[30:23]) + 126;
        end
        if (e <= 0) return 32'h0;
        if (e >= 255) return {s, 8'hFF, m};
        return {s, 8'(e), m};
    endfunction

    // Runs one division; counts ce-high clocks until stall drops
    task automatic run_div(input string name, input logic [31:0] xa, input logic [31:0] ya,
                           input bit rand_ce, output logic [31:0] zr, output int nce);
        bit timeout;
        @(negedge clk);
        bus.x   = xa;
        bus.y   = ya;
        bus.run = 1'b1;
        bus.ce  = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        check({name, "_stall_start"}, 32'(bus.stall), 32'd1);
        nce     = 0;
        timeout = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            if (bus.ce) nce++;
            @(negedge clk);
            if (!bus.stall) begin
                timeout = 1'b0;
                break;
            end
            bus.ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check({name, "_timeout"}, 32'(timeout), 32'd0);
        zr      = bus.z;
        bus.run = 1'b0;
        bus.ce  = 1'b1;
    endtask

    // Starts a division and lets it run for n ce clocks
    task automatic start_partial(input logic [31:0] xa, input logic [31:0] ya, input int n);
        @(negedge clk);
        bus.x   = xa;
        bus.y   = ya;
        bus.run = 1'b1;
        bus.ce  = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        logic [31:0] zr;
        logic [31:0] a;
        logic [31:0] b;
        int          nce;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{"six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000};
        vecs[1] = '{"one_by_three",32'h3F800000, 32'h40400000, 32'h3EAAAAAA};
        vecs[2] = '{"neg_by_half", 32'hBF800000, 32'h3F000000, 32'hC0000000};
        vecs[3] = '{"zero_by_pi",  32'h00000000, 32'h40490FDB, 32'h00000000};
        vecs[4] = '{"one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000};
        vecs[5] = '{"nzero_by_0",  32'h80000000, 32'h00000000, 32'h00000000};
        vecs[6] = '{"underflow",   32'h00800000, 32'h7F000000, 32'h00000000};
        vecs[7] = '{"overflow",    32'h7F000000, 32'h00800000, 32'h7F800000};
        vecs[8] = '{"neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000};
        vecs[9] = '{"self_div",    32'h4049_0FDB, 32'h4049_0FDB, 32'h3F800000};

        // Reset state
        rst     = 1'b0;
        bus.ce  = 1'b0;
        bus.run = 1'b0;
        bus.x   = 32'h0;
        bus.y   = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 32'(bus.stall), 32'd0);
        check("reset_z", bus.z, 32'h0);
        check("reset_s", 32'(dut.r_s), 32'd0);
        rst = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            run_div(vecs[i].name, vecs[i].x, vecs[i].y, 1'b0, zr, nce);
            check({vecs[i].name, "_z"}, zr, vecs[i].z);
            check({vecs[i].name, "_latency"}, 32'(nce), 32'd26);
        end

        // Random ce gaps must not change latency in ce clocks or the result
        for (int k = 0; k < 3; k++) begin
            run_div("ce_gap", 32'h40C00000, 32'h40000000, 1'b1, zr, nce);
            check("ce_gap_z", zr, 32'h40400000);
            check("ce_gap_latency", 32'(nce), 32'd26);
        end

        // Asynchronous reset mid-division
        start_partial(32'h40C00000, 32'h40000000, 12);
        #2;
        check("pre_rst_s", 32'(dut.r_s), 32'd12);
        rst = 1'b0;
        #1;
        check("rst_async_s", 32'(dut.r_s), 32'd0);
        check("rst_async_r", 32'(dut.r_r), 32'd0);
        check("rst_async_q", 32'(dut.r_q), 32'd0);
        check("rst_stall_run1", 32'(bus.stall), 32'd1);
        bus.run = 1'b0;
        #1;
        check("rst_stall_run0", 32'(bus.stall), 32'd0);
        bus.x = 32'h0;
        #1;
        check("rst_z_xzero", bus.z, 32'h0);
        bus.run = 1'b1;
        @(posedge clk);
        #1;
        check("rst_holds_s", 32'(dut.r_s), 32'd0);
        @(negedge clk);
        bus.run = 1'b0;
        rst     = 1'b1;
        run_div("post_rst", 32'h40C00000, 32'h40000000, 1'b0, zr, nce);
        check("post_rst_z", zr, 32'h40400000);
        check("post_rst_latency", 32'(nce), 32'd26);

        // Abort at S=10 then restart with a different division
        start_partial(32'h40C00000, 32'h40000000, 10);
        @(negedge clk);
        bus.run = 1'b0;
        @(posedge clk);
        #1;
        check("abort_s", 32'(dut.r_s), 32'd0);
        run_div("restart", 32'h3F800000, 32'h40400000, 1'b0, zr, nce);
        check("restart_z", zr, 32'h3EAAAAAA);
        check("restart_latency", 32'(nce), 32'd26);

        // Randomized divisions against the reference model
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 8)
                0: a[30:23] = 8'd0;
                1: b[30:23] = 8'd0;
                2: begin a[30:23] = 8'($urandom_range(1, 8));    b[30:23] = 8'($urandom_range(200, 254)); end
                3: begin a[30:23] = 8'($urandom_range(200, 254)); b[30:23] = 8'($urandom_range(1, 8)); end
                4: begin a[30:23] = 8'($urandom_range(100, 150)); b[30:23] = 8'($urandom_range(100, 150)); end
                default: ;
            endcase
            run_div("rand", a, b, i[0], zr, nce);
            check("rand_z", zr, ref_div(a, b));
            check("rand_latency", 32'(nce), 32'd26);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
